// File: rtl/scv_vram_arbiter_if.sv
// rtl/scv_vram_arbiter_if.sv - CPU, video and RAM signal bundle for the VRAM arbiter
interface scv_vram_arbiter_if #(
    parameter int AW = 12
);
    logic          CPU_REQ;
    logic          CPU_WE;
    logic [AW-1:0] CPU_A;
    logic [7:0]    CPU_D_I;
    logic [7:0]    CPU_D_O;
    logic          CPU_ACK;

    logic          VID_PRI;
    logic          VID_REQ;
    logic [AW-1:0] VID_A;
    logic          VID_GNT;
    logic [7:0]    VID_D_O;
    logic          VID_VALID;

    logic          RAM_CE;
    logic          RAM_WE;
    logic [AW-1:0] RAM_A;
    logic [7:0]    RAM_D;
    logic [7:0]    RAM_Q;

    modport slave (
        input  CPU_REQ, CPU_WE, CPU_A, CPU_D_I, VID_PRI, VID_REQ, VID_A, RAM_Q,
        output CPU_D_O, CPU_ACK, VID_GNT, VID_D_O, VID_VALID,
        output RAM_CE, RAM_WE, RAM_A, RAM_D
    );

    modport master (
        output CPU_REQ, CPU_WE, CPU_A, CPU_D_I, VID_PRI, VID_REQ, VID_A, RAM_Q,
        input  CPU_D_O, CPU_ACK, VID_GNT, VID_D_O, VID_VALID,
        input  RAM_CE, RAM_WE, RAM_A, RAM_D
    );
endinterface

// File: rtl/scv_vram_arbiter.sv
// rtl/scv_vram_arbiter.sv - single-port VRAM arbiter between uPD7800 CPU and video fetch
// One grant per cycle, data returned to the owner two cycles after its grant.
module scv_vram_arbiter #(
    parameter int AW        = 12,
    parameter int MAX_DEFER = 4,
    parameter int CW        = 3
) (
    input  logic               CLK,
    input  logic               RESET,
    scv_vram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU_RD,
        OWN_CPU_WR,
        OWN_VID
    } owner_t;

    localparam logic [CW-1:0] DEFER_MAX = CW'(MAX_DEFER);

    owner_t        t1;
    owner_t        t2;
    logic          cpu_busy;
    logic [CW-1:0] defer_cnt;
    logic          ram_ce_q;
    logic          ram_we_q;
    logic [AW-1:0] ram_a_q;
    logic [7:0]    ram_d_q;
    logic [7:0]    cpu_d_q;
    logic [7:0]    vid_d_q;

    logic          cpu_elig;
    logic          vid_elig;
    logic          defer_full;
    logic          cpu_win;
    logic          vid_win;
    logic          cpu_ack;

    always_comb begin
        cpu_elig   = 1'b0;
        vid_elig   = 1'b0;
        defer_full = 1'b0;
        cpu_win    = 1'b0;
        vid_win    = 1'b0;
        cpu_ack    = 1'b0;

        cpu_elig   = bus.CPU_REQ & ~cpu_busy;
        vid_elig   = bus.VID_REQ;
        defer_full = (defer_cnt == DEFER_MAX);
        // Video only wins a tie during active display, and only until the CPU has waited long enough.
        cpu_win    = ~RESET & cpu_elig & (~vid_elig | ~bus.VID_PRI | defer_full);
        vid_win    = ~RESET & vid_elig & ~cpu_win;
        cpu_ack    = (t2 == OWN_CPU_RD) | (t2 == OWN_CPU_WR);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            t1        <= OWN_NONE;
            t2        <= OWN_NONE;
            cpu_busy  <= 1'b0;
            defer_cnt <= '0;
            ram_ce_q  <= 1'b0;
            ram_we_q  <= 1'b0;
            ram_a_q   <= '0;
            ram_d_q   <= '0;
            cpu_d_q   <= '0;
            vid_d_q   <= '0;
        end else begin
            t2 <= t1;
            if (t1 == OWN_VID)    vid_d_q <= bus.RAM_Q;
            if (t1 == OWN_CPU_RD) cpu_d_q <= bus.RAM_Q;

            if (cpu_win) begin
                cpu_busy  <= 1'b1;
                defer_cnt <= '0;
                ram_ce_q  <= 1'b1;
                ram_we_q  <= bus.CPU_WE;
                ram_a_q   <= bus.CPU_A;
                if (bus.CPU_WE) ram_d_q <= bus.CPU_D_I;
                t1 <= bus.CPU_WE ? OWN_CPU_WR : OWN_CPU_RD;
            end else begin
                // The busy flag outlives the ACK cycle so a still-held request is not granted twice.
                if (cpu_ack) cpu_busy <= 1'b0;
                if (vid_win) begin
                    ram_ce_q <= 1'b1;
                    ram_we_q <= 1'b0;
                    ram_a_q  <= bus.VID_A;
                    t1       <= OWN_VID;
                    if (cpu_elig && !defer_full) defer_cnt <= defer_cnt + CW'(1);
                end else begin
                    ram_ce_q <= 1'b0;
                    ram_we_q <= 1'b0;
                    t1       <= OWN_NONE;
                end
            end
        end
    end

    assign bus.VID_GNT   = vid_win;
    assign bus.CPU_ACK   = cpu_ack;
    assign bus.VID_VALID = (t2 == OWN_VID);
    assign bus.CPU_D_O   = cpu_d_q;
    assign bus.VID_D_O   = vid_d_q;
    assign bus.RAM_CE    = ram_ce_q;
    assign bus.RAM_WE    = ram_we_q;
    assign bus.RAM_A     = ram_a_q;
    assign bus.RAM_D     = ram_d_q;
endmodule
